imem_arbiter: RTL and testbench

- Shares the single-read-port instruction ROM between two requesters: instruction fetch (IF) and the load unit (LS), which reads constants and .rodata out of ROM.
- Selects the ROM address each cycle and tracks the ROM's fixed 1-cycle read latency.
- Routes returned data to the requester that was granted.
- Load priority with a starvation guard for fetch; fetch flush squashes an in-flight fetch read.

---
 rtl/imem_arbiter_pkg.sv | 22 ++
 rtl/imem_arbiter_prio_sel.sv | 52 +++++
 rtl/imem_arbiter.sv | 101 ++++++++++
 tb/tb_imem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_arbiter_pkg.sv
// imem_arbiter_pkg
//   Shared definitions for the instruction-ROM arbiter slice: default
//   geometry (word-address and data widths), the fetch starvation limit,
//   the response-owner encoding and the starvation counter width.
package imem_arbiter_pkg;

  localparam int AWIDTH_DEF  = 12;
  localparam int DWIDTH_DEF  = 32;
  localparam int WORDS_DEF   = 1 << AWIDTH_DEF;
  localparam int MAXWAIT_DEF = 3;

  // The counter must hold MAXWAIT, whose legal range is 1..15.
  localparam int CNT_W = 4;

  // Owner of the read that returns from the ROM in the next cycle.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IF   = 2'd1,
    OWN_LS   = 2'd2
  } owner_e;

endpackage

// File: rtl/imem_arbiter_prio_sel.sv
// imem_arbiter_prio_sel
//   Two-way priority select with a starvation guard. The high-priority
//   requester wins a conflict unless the low-priority requester has already
//   lost MAXWAIT consecutive cycles, in which case the low-priority side is
//   forced through once.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   lo_req      eligible low-priority request (already qualified by caller)
//   hi_req      eligible high-priority request
//   lo_gnt      low-priority grant (combinational)
//   hi_gnt      high-priority grant (combinational)
module imem_arbiter_prio_sel
  import imem_arbiter_pkg::*;
#(
  parameter int MAXWAIT = MAXWAIT_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic lo_req,
  input  logic hi_req,
  output logic lo_gnt,
  output logic hi_gnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAXWAIT);

  logic [CNT_W-1:0] starve_cnt_reg;
  logic [CNT_W-1:0] starve_cnt_next;
  logic             starved;

  assign starved = (starve_cnt_reg == CNT_MAX);
  assign lo_gnt  = lo_req && (!hi_req || starved);
  assign hi_gnt  = hi_req && !lo_gnt;

  // Counts only consecutive denied cycles; any cycle where the low side is
  // not asking (or is granted) starts the count over.
  always_comb begin
    starve_cnt_next = '0;
    if (lo_req && !lo_gnt) begin
      starve_cnt_next = starved ? starve_cnt_reg : starve_cnt_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt_reg <= '0;
    end else begin
      starve_cnt_reg <= starve_cnt_next;
    end
  end

endmodule

// File: rtl/imem_arbiter.sv
// imem_arbiter
//   Shares the single read port of the instruction ROM between instruction
//   fetch (IF) and the load unit (LS). One grant per cycle, load priority
//   with a starvation guard for fetch. The ROM has a fixed 1-cycle read
//   latency; the returned word is routed to whoever was granted the cycle
//   before. A fetch flush kills the fetch grant and masks a fetch response
//   returning in the same cycle.
// Ports:
//   clk, rst_n                       clock, asynchronous active-low reset
//   if_req, if_addr, if_flush        fetch request, word address, flush
//   if_gnt, if_rvalid, if_rdata      fetch grant, response valid, data
//   ls_req, ls_addr                  load request, word address
//   ls_gnt, ls_rvalid, ls_rdata      load grant, response valid, data
//   rom_addr                         address presented to the ROM
//   rom_qout                         registered ROM read data
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int AWIDTH  = AWIDTH_DEF,
  parameter int DWIDTH  = DWIDTH_DEF,
  parameter int MAXWAIT = MAXWAIT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [AWIDTH-1:0] if_addr,
  input  logic              if_flush,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DWIDTH-1:0] if_rdata,
  input  logic              ls_req,
  input  logic [AWIDTH-1:0] ls_addr,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DWIDTH-1:0] ls_rdata,
  output logic [AWIDTH-1:0] rom_addr,
  input  logic [DWIDTH-1:0] rom_qout
);

  logic              if_elig;
  logic              if_gnt_raw;
  logic              ls_gnt_raw;
  owner_e            owner_reg;
  owner_e            owner_next;
  logic [AWIDTH-1:0] last_addr_reg;
  logic [AWIDTH-1:0] addr_sel;

  assign if_elig = if_req && !if_flush;

  imem_arbiter_prio_sel #(
    .MAXWAIT (MAXWAIT)
  ) u_prio_sel (
    .clk    (clk),
    .rst_n  (rst_n),
    .lo_req (if_elig),
    .hi_req (ls_req),
    .lo_gnt (if_gnt_raw),
    .hi_gnt (ls_gnt_raw)
  );

  // Grants are combinational from the requests; hold them low while reset
  // is asserted so nothing is accepted that the reset would then discard.
  // Registered state is fed from the ungated path because reset already
  // holds those flops.
  assign if_gnt = rst_n && if_gnt_raw;
  assign ls_gnt = rst_n && ls_gnt_raw;

  // With no grant the ROM keeps seeing the last granted address instead of
  // whatever an ungranted requester happens to be driving.
  assign addr_sel = if_gnt_raw ? if_addr : (ls_gnt_raw ? ls_addr : last_addr_reg);
  assign rom_addr = if_gnt ? if_addr : (ls_gnt ? ls_addr : last_addr_reg);

  always_comb begin
    owner_next = OWN_NONE;
    if (if_gnt_raw) begin
      owner_next = OWN_IF;
    end else if (ls_gnt_raw) begin
      owner_next = OWN_LS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      owner_reg     <= OWN_NONE;
      last_addr_reg <= '0;
    end else begin
      owner_reg <= owner_next;
      if (if_gnt_raw || ls_gnt_raw) begin
        last_addr_reg <= addr_sel;
      end
    end
  end

  // A flush in the return cycle drops the fetch word immediately; the load
  // side never sees the flush.
  assign if_rvalid = (owner_reg == OWN_IF) && !if_flush;
  assign ls_rvalid = (owner_reg == OWN_LS);
  assign if_rdata  = if_rvalid ? rom_qout : '0;
  assign ls_rdata  = ls_rvalid ? rom_qout : '0;

endmodule

// File: tb/tb_imem_arbiter.sv
module tb_imem_arbiter;

  logic        clk;
  logic        rst_n;
  logic        if_req;
  logic [11:0] if_addr;
  logic        if_flush;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        ls_req;
  logic [11:0] ls_addr;
  logic        ls_gnt;
  logic        ls_rvalid;
  logic [31:0] ls_rdata;
  logic [11:0] rom_addr;
  logic [31:0] rom_qout;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int          own;   // 0 none, 1 fetch, 2 load
    logic [11:0] addr;
  } sb_t;

  typedef struct {
    logic        iv;
    logic [31:0] id;
    logic        lv;
    logic [31:0] ld;
    logic [11:0] addr;
  } exp_t;

  sb_t         sb_q[$];
  logic [11:0] last_addr;

  imem_arbiter #(
    .AWIDTH  (12),
    .DWIDTH  (32),
    .MAXWAIT (3)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_flush  (if_flush),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .ls_req    (ls_req),
    .ls_addr   (ls_addr),
    .ls_gnt    (ls_gnt),
    .ls_rvalid (ls_rvalid),
    .ls_rdata  (ls_rdata),
    .rom_addr  (rom_addr),
    .rom_qout  (rom_qout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ROM model: content is a distinct function of the address.
  function automatic logic [31:0] rom_word(input logic [11:0] a);
    return {a, 8'h5A, ~a};
  endfunction

  always @(posedge clk) rom_qout <= rom_word(rom_addr);

  task automatic drive(input logic ifr, input logic [11:0] ifa, input logic fl,
                       input logic lsr, input logic [11:0] lsa);
    if_req   = ifr;
    if_addr  = ifa;
    if_flush = fl;
    ls_req   = lsr;
    ls_addr  = lsa;
    @(negedge clk);
  endtask

  task automatic next_edge();
    @(posedge clk);
    #1;
  endtask

  // Pops the read that returns this cycle and pushes the one granted now.
  task automatic sb_step(input logic eig, input logic elg, input logic fl,
                         input logic [11:0] ifa, input logic [11:0] lsa,
                         output exp_t e);
    sb_t s;
    if (sb_q.size() > 0) begin
      s = sb_q.pop_front();
    end else begin
      s.own  = 0;
      s.addr = '0;
    end
    e.iv   = (s.own == 1) && !fl;
    e.id   = e.iv ? rom_word(s.addr) : 32'h0;
    e.lv   = (s.own == 2);
    e.ld   = e.lv ? rom_word(s.addr) : 32'h0;
    e.addr = eig ? ifa : (elg ? lsa : last_addr);
    if (eig || elg) last_addr = e.addr;
    s.own  = eig ? 1 : (elg ? 2 : 0);
    s.addr = e.addr;
    sb_q.push_back(s);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 12'h123, 1'b0, 1'b1, 12'h321);
      total++; if (if_gnt !== 1'b0 || ls_gnt !== 1'b0) begin bad++;
        $display("FAIL reset_gnt cyc=%0d got if=%b ls=%b exp 0/0", i, if_gnt, ls_gnt); end
      total++; if (if_rvalid !== 1'b0 || ls_rvalid !== 1'b0) begin bad++;
        $display("FAIL reset_rvalid cyc=%0d got if=%b ls=%b exp 0/0", i, if_rvalid, ls_rvalid); end
      total++; if (if_rdata !== 32'h0 || ls_rdata !== 32'h0) begin bad++;
        $display("FAIL reset_rdata cyc=%0d got if=%h ls=%h exp 0/0", i, if_rdata, ls_rdata); end
      total++; if (rom_addr !== 12'h000) begin bad++;
        $display("FAIL reset_rom_addr cyc=%0d got=%h exp=000", i, rom_addr); end
      $display("reset cyc=%0d if_gnt=%b ls_gnt=%b rom_addr=%h", i, if_gnt, ls_gnt, rom_addr);
      next_edge();
    end
    drive(1'b0, 12'h000, 1'b0, 1'b0, 12'h000);
    rst_n = 1'b1;
    sb_q.delete();
    last_addr = '0;
    next_edge();
  endtask

  task automatic test_if_stream();
    exp_t e;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 12'h010, 1'b0, 1'b0, 12'h000);
      sb_step(1'b1, 1'b0, 1'b0, 12'h010, 12'h000, e);
      total++; if (if_gnt !== 1'b1 || ls_gnt !== 1'b0) begin bad++;
        $display("FAIL stream_gnt cyc=%0d got if=%b ls=%b exp 1/0", i, if_gnt, ls_gnt); end
      total++; if (rom_addr !== e.addr) begin bad++;
        $display("FAIL stream_addr cyc=%0d got=%h exp=%h", i, rom_addr, e.addr); end
      total++; if (if_rvalid !== e.iv || if_rdata !== e.id) begin bad++;
        $display("FAIL stream_if_resp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, if_rvalid, if_rdata, e.iv, e.id); end
      total++; if (ls_rvalid !== e.lv || ls_rdata !== e.ld) begin bad++;
        $display("FAIL stream_ls_resp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, ls_rvalid, ls_rdata, e.lv, e.ld); end
      $display("stream cyc=%0d if_gnt=%b if_rvalid=%b if_rdata=%h", i, if_gnt, if_rvalid, if_rdata);
      next_edge();
    end
  endtask

  // Cycle 0 idles to clear the starvation count, then both request for 8
  // cycles: load, load, load, fetch, load, load, load, fetch.
  task automatic test_starvation();
    exp_t e;
    logic act, eig, elg;
    for (int i = 0; i < 9; i++) begin
      act = (i != 0);
      eig = (i == 4) || (i == 8);
      elg = act && !eig;
      drive(act, 12'h020, 1'b0, act, 12'h030);
      sb_step(eig, elg, 1'b0, 12'h020, 12'h030, e);
      total++; if (if_gnt !== eig || ls_gnt !== elg) begin bad++;
        $display("FAIL starve_gnt cyc=%0d got if=%b ls=%b exp if=%b ls=%b", i, if_gnt, ls_gnt, eig, elg); end
      total++; if (rom_addr !== e.addr) begin bad++;
        $display("FAIL starve_addr cyc=%0d got=%h exp=%h", i, rom_addr, e.addr); end
      total++; if (if_rvalid !== e.iv || if_rdata !== e.id) begin bad++;
        $display("FAIL starve_if_resp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, if_rvalid, if_rdata, e.iv, e.id); end
      total++; if (ls_rvalid !== e.lv || ls_rdata !== e.ld) begin bad++;
        $display("FAIL starve_ls_resp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, ls_rvalid, ls_rdata, e.lv, e.ld); end
      $display("starve cyc=%0d if_gnt=%b ls_gnt=%b rom_addr=%h", i, if_gnt, ls_gnt, rom_addr);
      next_edge();
    end
  endtask

  // Fetch grant, then flush while both request, then idle.
  task automatic test_flush();
    exp_t e;
    logic ifr, fl, lsr, eig, elg;
    for (int i = 0; i < 3; i++) begin
      ifr = (i < 2);
      fl  = (i == 1);
      lsr = (i == 1);
      eig = (i == 0);
      elg = (i == 1);
      drive(ifr, 12'h040, fl, lsr, 12'h044);
      sb_step(eig, elg, fl, 12'h040, 12'h044, e);
      total++; if (if_gnt !== eig || ls_gnt !== elg) begin bad++;
        $display("FAIL flush_gnt cyc=%0d got if=%b ls=%b exp if=%b ls=%b", i, if_gnt, ls_gnt, eig, elg); end
      total++; if (rom_addr !== e.addr) begin bad++;
        $display("FAIL flush_addr cyc=%0d got=%h exp=%h", i, rom_addr, e.addr); end
      total++; if (if_rvalid !== e.iv || if_rdata !== e.id) begin bad++;
        $display("FAIL flush_if_resp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, if_rvalid, if_rdata, e.iv, e.id); end
      total++; if (ls_rvalid !== e.lv || ls_rdata !== e.ld) begin bad++;
        $display("FAIL flush_ls_resp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, ls_rvalid, ls_rdata, e.lv, e.ld); end
      $display("flush cyc=%0d if_flush=%b if_gnt=%b ls_gnt=%b if_rvalid=%b", i, fl, if_gnt, ls_gnt, if_rvalid);
      next_edge();
    end
  endtask

  // Load grant at 0x055 then three idle cycles: address must hold.
  task automatic test_addr_hold();
    exp_t e;
    logic elg;
    for (int i = 0; i < 4; i++) begin
      elg = (i == 0);
      drive(1'b0, 12'h7AA, 1'b0, elg, elg ? 12'h055 : 12'h0EE);
      sb_step(1'b0, elg, 1'b0, 12'h7AA, 12'h055, e);
      total++; if (if_gnt !== 1'b0 || ls_gnt !== elg) begin bad++;
        $display("FAIL hold_gnt cyc=%0d got if=%b ls=%b exp if=0 ls=%b", i, if_gnt, ls_gnt, elg); end
      total++; if (rom_addr !== 12'h055) begin bad++;
        $display("FAIL hold_addr cyc=%0d got=%h exp=055", i, rom_addr); end
      total++; if (if_rvalid !== e.iv || if_rdata !== e.id) begin bad++;
        $display("FAIL hold_if_resp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, if_rvalid, if_rdata, e.iv, e.id); end
      total++; if (ls_rvalid !== e.lv || ls_rdata !== e.ld) begin bad++;
        $display("FAIL hold_ls_resp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, ls_rvalid, ls_rdata, e.lv, e.ld); end
      $display("hold cyc=%0d rom_addr=%h ls_rvalid=%b", i, rom_addr, ls_rvalid);
      next_edge();
    end
  endtask

  // Reset lands the cycle after a fetch grant; the in-flight word is lost.
  task automatic test_reset_mid();
    exp_t e;
    logic eig;
    drive(1'b1, 12'h0A0, 1'b0, 1'b0, 12'h000);
    sb_step(1'b1, 1'b0, 1'b0, 12'h0A0, 12'h000, e);
    total++; if (if_gnt !== 1'b1) begin bad++;
      $display("FAIL midrst_pre_gnt got=%b exp=1", if_gnt); end
    $display("midrst pre if_gnt=%b rom_addr=%h", if_gnt, rom_addr);
    next_edge();
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      total++; if (if_rvalid !== 1'b0 || if_rdata !== 32'h0) begin bad++;
        $display("FAIL midrst_if_resp cyc=%0d got v=%b d=%h exp v=0 d=0", i, if_rvalid, if_rdata); end
      total++; if (if_gnt !== 1'b0 || ls_rvalid !== 1'b0) begin bad++;
        $display("FAIL midrst_gnt cyc=%0d got if_gnt=%b ls_rvalid=%b exp 0/0", i, if_gnt, ls_rvalid); end
      $display("midrst in-reset cyc=%0d if_rvalid=%b if_rdata=%h", i, if_rvalid, if_rdata);
      next_edge();
    end
    if_req = 1'b0;
    rst_n = 1'b1;
    sb_q.delete();
    last_addr = '0;
    for (int i = 0; i < 3; i++) begin
      eig = (i == 1);
      drive(eig, 12'h0AB, 1'b0, 1'b0, 12'h000);
      sb_step(eig, 1'b0, 1'b0, 12'h0AB, 12'h000, e);
      total++; if (if_gnt !== eig || ls_gnt !== 1'b0) begin bad++;
        $display("FAIL midrst_post_gnt cyc=%0d got if=%b ls=%b exp if=%b ls=0", i, if_gnt, ls_gnt, eig); end
      total++; if (rom_addr !== e.addr) begin bad++;
        $display("FAIL midrst_post_addr cyc=%0d got=%h exp=%h", i, rom_addr, e.addr); end
      total++; if (if_rvalid !== e.iv || if_rdata !== e.id) begin bad++;
        $display("FAIL midrst_post_if_resp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, if_rvalid, if_rdata, e.iv, e.id); end
      $display("midrst post cyc=%0d if_gnt=%b if_rvalid=%b if_rdata=%h", i, if_gnt, if_rvalid, if_rdata);
      next_edge();
    end
  endtask

  // Alternating single-cycle fetch/load requests, including address 0xFFF.
  task automatic test_back_to_back();
    exp_t e;
    logic eig, elg;
    logic [11:0] ia, la;
    for (int i = 0; i < 9; i++) begin
      eig = (i < 8) && (i % 2 == 0);
      elg = (i < 8) && (i % 2 == 1);
      ia  = 12'(12'h100 + i);
      la  = 12'(12'hFF8 + i);
      drive(eig, ia, 1'b0, elg, la);
      sb_step(eig, elg, 1'b0, ia, la, e);
      total++; if (if_gnt !== eig || ls_gnt !== elg) begin bad++;
        $display("FAIL b2b_gnt cyc=%0d got if=%b ls=%b exp if=%b ls=%b", i, if_gnt, ls_gnt, eig, elg); end
      total++; if (rom_addr !== e.addr) begin bad++;
        $display("FAIL b2b_addr cyc=%0d got=%h exp=%h", i, rom_addr, e.addr); end
      total++; if (if_rvalid !== e.iv || if_rdata !== e.id) begin bad++;
        $display("FAIL b2b_if_resp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, if_rvalid, if_rdata, e.iv, e.id); end
      total++; if (ls_rvalid !== e.lv || ls_rdata !== e.ld) begin bad++;
        $display("FAIL b2b_ls_resp cyc=%0d got v=%b d=%h exp v=%b d=%h", i, ls_rvalid, ls_rdata, e.lv, e.ld); end
      $display("b2b cyc=%0d if_gnt=%b ls_gnt=%b rom_addr=%h if_rvalid=%b ls_rvalid=%b", i, if_gnt, ls_gnt, rom_addr, if_rvalid, ls_rvalid);
      next_edge();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    if_req    = 1'b0;
    if_addr   = '0;
    if_flush  = 1'b0;
    ls_req    = 1'b0;
    ls_addr   = '0;
    last_addr = '0;
    #1;
    test_reset();
    test_if_stream();
    test_starvation();
    test_flush();
    test_addr_hold();
    test_reset_mid();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
